// File: rtl/scaler_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scaler_ctrl
// Purpose  : Frame-synchronous sequencer placed in front of the scaler.
//            It latches host scale settings, measures the input line width
//            on a blanked frame and computes reg_v_scale_inline_size with a
//            16-cycle restoring divider. Video reaches the scaler only while
//            the reg_* outputs match the incoming frame.
// Ports    : clk, rst (async, active-high)
//            cfg_h/v_scale_step, cfg_wr  - host settings, captured on strobe
//            di_i/de_i/hs_i/vs_i         - incoming video
//            do_o/de_o/hs_o/vs_o         - gated video, 1-cycle latency
//            reg_h/v_scale_step, reg_v_scale_inline_size - scaler config
//            in_width_o                  - width used for the current config
//            busy_o (not RUN), err_o (sticky, cleared by cfg_wr)
// Revision : 1.0 - initial release
// ============================================================================
module scaler_ctrl #(
   parameter int PIXEL_WIDTH      = 8,
   parameter int SCALE_STEP       = 128,
   parameter int LINE_IN_SIZE_MAX = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [15:0]            cfg_h_scale_step,
   input  logic [15:0]            cfg_v_scale_step,
   input  logic                   cfg_wr,
   input  logic [PIXEL_WIDTH-1:0] di_i,
   input  logic                   de_i,
   input  logic                   hs_i,
   input  logic                   vs_i,
   output logic [PIXEL_WIDTH-1:0] do_o,
   output logic                   de_o,
   output logic                   hs_o,
   output logic                   vs_o,
   output logic [15:0]            reg_h_scale_step,
   output logic [15:0]            reg_v_scale_step,
   output logic [15:0]            reg_v_scale_inline_size,
   output logic [15:0]            in_width_o,
   output logic                   busy_o,
   output logic                   err_o
);

   localparam int          SHIFT = $clog2(SCALE_STEP);
   localparam int          NW    = 16 + SHIFT;
   localparam logic [15:0] MAX_W = 16'(LINE_IN_SIZE_MAX);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MEAS = 3'd1,
      S_CALC = 3'd2,
      S_ARM  = 3'd3,
      S_RUN  = 3'd4,
      S_WAIT = 3'd5
   } state_t;

   state_t        state, state_nxt;

   logic          vs_d, hs_d, fs, line_end;
   logic          in_first, meas_done;
   logic [15:0]   wcnt, meas_w;
   logic [15:0]   pend_h, pend_v;
   logic          pend_flag;
   logic [15:0]   act_h, act_v;
   logic          mism, pass, pass_eval, pass_nxt;
   logic          err_set, clr_pend, load_div, commit;

   // divider
   logic [NW-1:0] dividend, div_hi;
   logic [15:0]   rem, quo, rem_nxt, q_nxt, diff;
   logic [16:0]   trial;
   logic          q_bit, sat;
   logic [3:0]    calc_cnt;

   assign fs       = vs_i & ~vs_d;
   assign line_end = hs_i & ~hs_d;
   assign busy_o   = (state != S_RUN);

   // N = (meas_w - 1) * SCALE_STEP. The part above bit 15 seeds the
   // remainder; if it already reaches the divisor the quotient needs more
   // than 16 bits, which is the saturation case.
   assign dividend = {meas_w - 16'd1, {SHIFT{1'b0}}};
   assign div_hi   = dividend >> 16;

   // One restoring step: shift the next dividend bit into the remainder,
   // subtract when it fits. The quotient shifts in from the bottom of quo
   // as the low dividend bits shift out of its top.
   assign trial   = {rem, quo[15]};
   assign q_bit   = (trial >= {1'b0, act_h});
   assign diff    = trial[15:0] - act_h;
   assign rem_nxt = q_bit ? diff : trial[15:0];
   assign q_nxt   = {quo[14:0], q_bit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      err_set   = 1'b0;
      clr_pend  = 1'b0;
      load_div  = 1'b0;
      commit    = 1'b0;
      pass_eval = 1'b0;
      case (state)
         S_IDLE: if (fs && pend_flag) begin
            state_nxt = S_MEAS;
            clr_pend  = 1'b1;
         end
         S_MEAS: if (meas_done) begin
            if (meas_w == 16'd0 || meas_w > MAX_W) begin
               err_set   = 1'b1;
               state_nxt = S_WAIT;
            end else if (pend_h == 16'd0 || pend_v == 16'd0) begin
               err_set   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               load_div  = 1'b1;
               state_nxt = S_CALC;
            end
         end
         S_CALC: if (calc_cnt == 4'd15) begin
            if (sat || q_nxt < 16'd2) begin
               err_set   = 1'b1;
               state_nxt = S_WAIT;
            end else begin
               commit    = 1'b1;
               state_nxt = S_ARM;
            end
         end
         S_ARM: if (fs) begin
            pass_eval = 1'b1;
            state_nxt = S_RUN;
         end
         S_RUN: if (fs) begin
            if (pend_flag || mism) begin
               clr_pend  = 1'b1;
               state_nxt = S_MEAS;
            end else begin
               pass_eval = 1'b1;
            end
         end
         S_WAIT: if (fs) begin
            clr_pend  = 1'b1;
            state_nxt = S_MEAS;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // The forward decision is taken only at frame start so a frame is never
   // cut in half; the new value already applies to the FS cycle itself.
   assign pass_nxt = fs ? pass_eval : pass;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_d                    <= 1'b0;
         hs_d                    <= 1'b1;
         in_first                <= 1'b0;
         meas_done               <= 1'b0;
         wcnt                    <= '0;
         meas_w                  <= '0;
         pend_h                  <= '0;
         pend_v                  <= '0;
         pend_flag               <= 1'b0;
         act_h                   <= '0;
         act_v                   <= '0;
         rem                     <= '0;
         quo                     <= '0;
         sat                     <= 1'b0;
         calc_cnt                <= '0;
         mism                    <= 1'b0;
         pass                    <= 1'b0;
         err_o                   <= 1'b0;
         reg_h_scale_step        <= '0;
         reg_v_scale_step        <= '0;
         reg_v_scale_inline_size <= '0;
         in_width_o              <= '0;
         do_o                    <= '0;
         de_o                    <= 1'b0;
         hs_o                    <= 1'b1;
         vs_o                    <= 1'b0;
      end else begin
         vs_d      <= vs_i;
         hs_d      <= hs_i;
         meas_done <= 1'b0;

         // first-line width counter, saturating at 16 bits
         if (fs) begin
            in_first <= 1'b1;
            wcnt     <= (de_i && !hs_i) ? 16'd1 : 16'd0;
         end else if (in_first) begin
            if (line_end) begin
               in_first  <= 1'b0;
               meas_w    <= wcnt;
               meas_done <= 1'b1;
            end else if (de_i && !hs_i && wcnt != 16'hFFFF) begin
               wcnt <= wcnt + 16'd1;
            end
         end

         // a strobe on the same cycle as a clear keeps the new request alive
         if (cfg_wr) begin
            pend_h    <= cfg_h_scale_step;
            pend_v    <= cfg_v_scale_step;
            pend_flag <= 1'b1;
         end else if (clr_pend) begin
            pend_flag <= 1'b0;
         end

         if (err_set)     err_o <= 1'b1;
         else if (cfg_wr) err_o <= 1'b0;

         if (load_div) begin
            act_h    <= pend_h;
            act_v    <= pend_v;
            rem      <= 16'(div_hi);
            quo      <= dividend[15:0];
            sat      <= (div_hi >= NW'(pend_h));
            calc_cnt <= '0;
         end else if (state == S_CALC) begin
            rem      <= rem_nxt;
            quo      <= q_nxt;
            calc_cnt <= calc_cnt + 4'd1;
         end

         if (commit) begin
            reg_h_scale_step        <= act_h;
            reg_v_scale_step        <= act_v;
            reg_v_scale_inline_size <= q_nxt - 16'd1;
            in_width_o              <= meas_w;
         end

         if (state == S_RUN && state_nxt != S_RUN)
            mism <= 1'b0;
         else if (state == S_RUN && meas_done && meas_w != in_width_o)
            mism <= 1'b1;

         pass <= pass_nxt;
         if (pass_nxt) begin
            do_o <= di_i;
            de_o <= de_i;
            hs_o <= hs_i;
            vs_o <= vs_i;
         end else begin
            do_o <= '0;
            de_o <= 1'b0;
            hs_o <= 1'b1;
            vs_o <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_scaler_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scaler_ctrl
// Purpose  : Self-checking bench for scaler_ctrl. Each driven video cycle
//            pushes its expected gated output into a queue, which is popped
//            and compared one cycle later. Configuration outputs are checked
//            at frame boundaries against hand-derived values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scaler_ctrl;

   localparam int PW    = 8;
   localparam int LINES = 3;
   localparam int HB    = 8;
   localparam int VB    = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   cfg_h_scale_step = '0;
   logic [15:0]   cfg_v_scale_step = '0;
   logic          cfg_wr = 1'b0;
   logic [PW-1:0] di_i = '0;
   logic          de_i = 1'b0;
   logic          hs_i = 1'b1;
   logic          vs_i = 1'b0;
   logic [PW-1:0] do_o;
   logic          de_o, hs_o, vs_o;
   logic [15:0]   reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size, in_width_o;
   logic          busy_o, err_o;

   always #5 clk = ~clk;

   scaler_ctrl #(
      .PIXEL_WIDTH      (PW),
      .SCALE_STEP       (128),
      .LINE_IN_SIZE_MAX (1024)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .cfg_h_scale_step        (cfg_h_scale_step),
      .cfg_v_scale_step        (cfg_v_scale_step),
      .cfg_wr                  (cfg_wr),
      .di_i                    (di_i),
      .de_i                    (de_i),
      .hs_i                    (hs_i),
      .vs_i                    (vs_i),
      .do_o                    (do_o),
      .de_o                    (de_o),
      .hs_o                    (hs_o),
      .vs_o                    (vs_o),
      .reg_h_scale_step        (reg_h_scale_step),
      .reg_v_scale_step        (reg_v_scale_step),
      .reg_v_scale_inline_size (reg_v_scale_inline_size),
      .in_width_o              (in_width_o),
      .busy_o                  (busy_o),
      .err_o                   (err_o)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [PW+2:0] exp_q[$];
   logic [15:0]   next_h = '0;
   logic [15:0]   next_v = '0;

   localparam logic [PW+2:0] BLANK = {{PW{1'b0}}, 1'b0, 1'b1, 1'b0};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic pop_check();
      logic [PW+2:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("video", 32'({do_o, de_o, hs_o, vs_o}), 32'(e));
      end
   endtask

   // one input cycle: check the previous cycle's output, drive, push expectation
   task automatic step(input logic de, input logic hs, input logic vs,
                       input logic [PW-1:0] d, input bit fwd, input bit cw);
      @(negedge clk);
      pop_check();
      de_i = de;
      hs_i = hs;
      vs_i = vs;
      di_i = d;
      cfg_wr = cw;
      cfg_h_scale_step = next_h;
      cfg_v_scale_step = next_v;
      exp_q.push_back(fwd ? {d, de, hs, vs} : BLANK);
   endtask

   task automatic idle(input int n, input bit cw_first);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0, cw_first && i == 0);
   endtask

   task automatic frame(input int w, input bit fwd, input int cfg_at);
      int cyc = 0;
      for (int l = 0; l < LINES; l++) begin
         for (int p = 0; p < w; p++) begin
            step(1'b1, 1'b0, 1'b1, PW'($urandom), fwd, cyc == cfg_at);
            cyc++;
         end
         for (int b = 0; b < HB; b++) begin
            step(1'b0, 1'b1, 1'b1, '0, fwd, cyc == cfg_at);
            cyc++;
         end
      end
      for (int b = 0; b < VB; b++) begin
         step(1'b0, 1'b1, 1'b0, '0, fwd, cyc == cfg_at);
         cyc++;
      end
   endtask

   task automatic check_cfg(input string tag, input int inl, input int wid,
                            input int h, input int v);
      check({tag, "_inline"}, 32'(reg_v_scale_inline_size), 32'(inl));
      check({tag, "_width"},  32'(in_width_o),              32'(wid));
      check({tag, "_hstep"},  32'(reg_h_scale_step),        32'(h));
      check({tag, "_vstep"},  32'(reg_v_scale_step),        32'(v));
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check("rst_video", 32'({do_o, de_o, hs_o, vs_o}), 32'(BLANK));
      check("rst_busy", 32'(busy_o), 32'd1);
      check("rst_err",  32'(err_o),  32'd0);
      check_cfg("rst", 0, 0, 0, 0);
      rst = 1'b0;
      idle(5, 1'b0);

      // h = v = 179, width 600: first frame blanked, second forwarded
      next_h = 16'd179; next_v = 16'd179;
      idle(5, 1'b1);
      frame(600, 1'b0, -1);
      check_cfg("cfg179", 427, 600, 179, 179);
      check("arm_busy", 32'(busy_o), 32'd1);
      frame(600, 1'b1, -1);
      check("run_busy", 32'(busy_o), 32'd0);
      check("run_err",  32'(err_o),  32'd0);

      // width drops to 300: that frame forwarded, next blanked, then forwarded
      frame(300, 1'b1, -1);
      frame(300, 1'b0, -1);
      check_cfg("w300", 212, 300, 179, 179);
      frame(300, 1'b1, -1);

      // cfg_wr mid-frame with h = 256: current frame forwarded unchanged
      next_h = 16'd256;
      frame(600, 1'b1, 100);
      check_cfg("midcfg_hold", 212, 300, 179, 179);
      frame(600, 1'b0, -1);
      check_cfg("h256", 298, 600, 256, 179);
      frame(600, 1'b1, -1);

      // h step 0: error, back to IDLE, stays blanked until a valid cfg
      next_h = 16'd0;
      idle(5, 1'b1);
      frame(600, 1'b0, -1);
      check("h0_err",  32'(err_o),  32'd1);
      check("h0_busy", 32'(busy_o), 32'd1);
      check("h0_inline_kept", 32'(reg_v_scale_inline_size), 32'd298);
      frame(600, 1'b0, -1);
      next_h = 16'd179;
      idle(5, 1'b1);
      check("h0_err_clr", 32'(err_o), 32'd0);
      frame(600, 1'b0, -1);
      check_cfg("recover", 427, 600, 179, 179);
      frame(600, 1'b1, -1);

      // width 1100: mismatch frame forwarded, then error and remeasure each frame
      frame(1100, 1'b1, -1);
      frame(1100, 1'b0, -1);
      check("w1100_err",  32'(err_o),  32'd1);
      check("w1100_busy", 32'(busy_o), 32'd1);
      frame(1100, 1'b0, -1);
      check("w1100_err2", 32'(err_o), 32'd1);
      // 1024 is the largest accepted width; err stays sticky
      frame(1024, 1'b0, -1);
      check_cfg("w1024", 730, 1024, 179, 179);
      check("w1024_err_sticky", 32'(err_o), 32'd1);
      frame(1024, 1'b1, -1);

      // reset mid-line while forwarding
      for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b1, PW'($urandom), 1'b1, 1'b0);
      @(negedge clk);
      pop_check();
      rst = 1'b1;
      de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0; di_i = '0;
      exp_q.delete();
      #1;
      check("midrst_video", 32'({do_o, de_o, hs_o, vs_o}), 32'(BLANK));
      check("midrst_busy", 32'(busy_o), 32'd1);
      check("midrst_err",  32'(err_o),  32'd0);
      check_cfg("midrst", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(20, 1'b0);
      frame(600, 1'b0, -1);
      check("postrst_busy", 32'(busy_o), 32'd1);
      check_cfg("postrst", 0, 0, 0, 0);

      // h = 1 with width 600: quotient overflows 16 bits -> error, WAIT
      next_h = 16'd1;
      idle(5, 1'b1);
      frame(600, 1'b0, -1);
      check("sat_err",  32'(err_o),  32'd1);
      check("sat_busy", 32'(busy_o), 32'd1);
      check_cfg("sat", 0, 0, 0, 0);

      idle(3, 1'b0);
      @(negedge clk);
      pop_check();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
